decode_stage: RTL and testbench
===============================

# decode_stage

Decode stage of the 8-bit pipeline. It accepts 16-bit instructions from fetch over a valid/ready handshake and drives register-file read addresses. It captures the registered read data and presents a decoded operand bundle to execute over a second valid/ready handshake. A 7-entry pending-write scoreboard stalls reads of registers that still have a write in flight from writeback.

## Interface
- No parameters; data width 8, register index width 3, instruction width 16 are fixed.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  decode can accept; = (state==IDLE) || (state==HOLD && out_ready); 0 while reset high
- in_instr  in  16  instruction word
- rf_rs  out  3  register-file RS read address (from held instruction)
- rf_rt  out  3  register-file RT read address
- rf_rs_data  in  8  register-file RS read data (registered, 1-cycle latency)
- rf_rt_data  in  8  register-file RT read data
- wb_valid  in  1  writeback writes register file this cycle (same signal as register-file rw)
- wb_rd  in  3  writeback destination
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute accepts bundle
- out_op  out  4  opcode
- out_rd  out  3  destination register (0 = no write)
- out_is_imm  out  1  I-type instruction
- out_imm  out  8  immediate (0 for R-type)
- out_a  out  8  RS operand
- out_b  out  8  RT operand (0 for I-type)

## Operation
- Format: [15:12] op, [11:9] rd. R-type (op[3]=0): [8:6] rs, [5:3] rt, [2:0] ignored. I-type (op[3]=1): rs=[11:9], rt=0, imm=[7:0], bit 8 ignored.
- op 4'h0 is NOP: rs=rt=rd=0. op 4'h6 (OUT) reads rs and has rd forced to 0. All other ops write rd.
- Register 0 reads as 0, never stalls, and never becomes busy.
- Scoreboard busy[7:1]: set busy[out_rd] on issue (out_valid && out_ready && out_rd!=0). Clear busy[wb_rd] when wb_valid. If set and clear hit the same index on one edge, set wins.
- FSM states:
  - IDLE: on in_valid && in_ready, latch the instruction and go to READ.
  - READ: rf_rs/rf_rt are driven from the held instruction. Stall (stay in READ) if wb_valid, busy[rs], or busy[rt]. A wb_valid stall is required because the register file drops reads on write cycles. Otherwise go to DATA.
  - DATA: register rf_rs_data/rf_rt_data into out_a/out_b (out_a=0 if rs=0; out_b=0 if rt=0 or I-type), set out_valid, go to HOLD.
  - HOLD: hold all out_* stable. On out_ready: if in_valid, accept the next instruction and go to READ; else clear out_valid and go to IDLE.
- Back-to-back dependency: an instruction whose rs equals the previous issued rd stalls in READ until the matching wb_valid edge, then stalls one more cycle (the write cycle itself), then reads.

## Timing
- Reset: state IDLE, busy=0, out_valid=0, all out_* = 0, held instruction = 0.
- Reset mid-operation discards the held instruction and the scoreboard; no issue occurs.
- No-stall latency: accept at edge t0 -> READ in cycle t0+1 -> DATA t0+2 -> out_valid high from cycle t0+3.
- Maximum throughput is one instruction per 3 cycles; issue and the next accept share the same edge.
- rf_rs/rf_rt change only on accept edges, stable through READ and DATA.
- out_* change only on the DATA->HOLD edge or on reset.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, all outputs 0. Release -> in_ready=1.
- Basic R-type: r2=0x11, r3=0x22, instr 0x1A98 (op1, rd5, rs2, rt3) accepted at t0 -> out_valid at t0+3 with op=1, rd=5, a=0x11, b=0x22, is_imm=0.
- I-type: instr 0x8C7F (op8, rd=rs=6) with r6=0x40 -> a=0x40, b=0, imm=0x7F, is_imm=1.
- RAW hazard: issue a write to r5, then accept an instruction reading r5. It stalls in READ until wb_valid/wb_rd=5 plus one cycle, then a = the newly written value.
- Writeback collision: wb_valid pulse to r1 during READ of an independent instruction -> one-cycle stall with correct data. wb_rd=5 on the same edge as issue of rd=5 -> busy[5] stays set.
- Backpressure and r0: out_ready=0 for 5 cycles -> outputs stable and in_ready=0. Reads of r0 give 0 with no stall. NOP and OUT never set busy.

Source files
------------

// File: rtl/decode_stage_if.sv
// Decode stage port bundle: fetch handshake, register-file read/writeback taps,
// and the operand bundle handshake toward execute.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [2:0]  rf_rs;
  logic [2:0]  rf_rt;
  logic [7:0]  rf_rs_data;
  logic [7:0]  rf_rt_data;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [2:0]  out_rd;
  logic        out_is_imm;
  logic [7:0]  out_imm;
  logic [7:0]  out_a;
  logic [7:0]  out_b;

  // Environment side: fetch, register file, writeback and execute.
  modport master (
    output in_valid, in_instr, rf_rs_data, rf_rt_data, wb_valid, wb_rd, out_ready,
    input  in_ready, rf_rs, rf_rt, out_valid, out_op, out_rd, out_is_imm, out_imm,
           out_a, out_b
  );

  // Decode stage side.
  modport slave (
    input  in_valid, in_instr, rf_rs_data, rf_rt_data, wb_valid, wb_rd, out_ready,
    output in_ready, rf_rs, rf_rt, out_valid, out_op, out_rd, out_is_imm, out_imm,
           out_a, out_b
  );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: holds one instruction, reads the register file with a pending-write
// scoreboard guarding RAW hazards, and presents a registered operand bundle.
module decode_stage (
  input  logic           clk,
  input  logic           reset,
  decode_stage_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRead, StData, StHold} state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  busy_q, busy_d;

  logic        out_valid_q;
  logic [3:0]  out_op_q;
  logic [2:0]  out_rd_q;
  logic        out_is_imm_q;
  logic [7:0]  out_imm_q;
  logic [7:0]  out_a_q;
  logic [7:0]  out_b_q;

  logic [3:0]  op;
  logic        is_imm;
  logic        is_nop;
  logic [2:0]  rs, rt, rd;
  logic [7:0]  imm;
  logic        in_ready;
  logic        accept;
  logic        issue;
  logic        stall;

  // Field decode of the held instruction.
  always_comb begin
    op     = instr_q[15:12];
    is_imm = op[3];
    is_nop = (op == 4'h0);
    rd     = (is_nop || op == 4'h6) ? 3'd0 : instr_q[11:9];
    rs     = is_nop ? 3'd0 : (is_imm ? instr_q[11:9] : instr_q[8:6]);
    rt     = (is_nop || is_imm) ? 3'd0 : instr_q[5:3];
    imm    = is_imm ? instr_q[7:0] : 8'h00;
  end

  assign in_ready = !reset && ((state_q == StIdle) || (state_q == StHold && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;
  assign issue    = (state_q == StHold) && bus.out_ready;
  // The register file drops reads on write cycles, so any writeback stalls too.
  assign stall    = bus.wb_valid || busy_q[rs] || busy_q[rt];

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          instr_d = bus.in_instr;
          state_d = StRead;
        end
      end
      StRead: begin
        if (!stall) state_d = StData;
      end
      StData: state_d = StHold;
      StHold: begin
        if (bus.out_ready) begin
          if (accept) begin
            instr_d = bus.in_instr;
            state_d = StRead;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Set on issue overrides a same-edge writeback clear.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid) busy_d[bus.wb_rd] = 1'b0;
    if (issue && out_rd_q != 3'd0) busy_d[out_rd_q] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      instr_q      <= 16'h0000;
      busy_q       <= 8'h00;
      out_valid_q  <= 1'b0;
      out_op_q     <= 4'h0;
      out_rd_q     <= 3'd0;
      out_is_imm_q <= 1'b0;
      out_imm_q    <= 8'h00;
      out_a_q      <= 8'h00;
      out_b_q      <= 8'h00;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      busy_q  <= busy_d;
      if (state_q == StData) begin
        out_valid_q  <= 1'b1;
        out_op_q     <= op;
        out_rd_q     <= rd;
        out_is_imm_q <= is_imm;
        out_imm_q    <= imm;
        out_a_q      <= (rs == 3'd0) ? 8'h00 : bus.rf_rs_data;
        out_b_q      <= (rt == 3'd0) ? 8'h00 : bus.rf_rt_data;
      end else if (issue) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.rf_rs      = rs;
  assign bus.rf_rt      = rt;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_op     = out_op_q;
  assign bus.out_rd     = out_rd_q;
  assign bus.out_is_imm = out_is_imm_q;
  assign bus.out_imm    = out_imm_q;
  assign bus.out_a      = out_a_q;
  assign bus.out_b      = out_b_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a registered-read register-file model
// that returns garbage on write cycles.
module tb_decode_stage;

  logic clk = 1'b0;
  logic reset;
  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] regs [8] = '{8'hAA, 8'h00, 8'h11, 8'h22, 8'h00, 8'h00, 8'h40, 8'h3C};
  logic [7:0] wb_data;

  always @(posedge clk) begin
    if (bus.wb_valid) begin
      regs[bus.wb_rd] <= wb_data;
      bus.rf_rs_data  <= 8'hEE;
      bus.rf_rt_data  <= 8'hEE;
    end else begin
      bus.rf_rs_data <= regs[bus.rf_rs];
      bus.rf_rt_data <= regs[bus.rf_rt];
    end
  end

  int n_pass  = 0;
  int n_total = 0;
  int lat;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] instr);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, {15'd0, bus.out_valid}, 16'd1);
  endtask

  task automatic issue();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic wb(input logic [2:0] r, input logic [7:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = r;
    wb_data      = d;
    step();
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_instr   = 16'h1A98;
    bus.wb_valid   = 1'b0;
    bus.wb_rd      = 3'd0;
    bus.out_ready  = 1'b0;
    bus.rf_rs_data = 8'h00;
    bus.rf_rt_data = 8'h00;
    wb_data        = 8'h00;

    // Reset with in_valid high
    step();
    step();
    chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd0);
    chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_outs", {bus.out_op, bus.out_rd, bus.out_is_imm, bus.out_a}, 16'd0);
    chk("rst_imm_b", {bus.out_imm, bus.out_b}, 16'd0);
    chk("rst_rf_addr", {10'd0, bus.rf_rs, bus.rf_rt}, 16'd0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rel_in_ready", {15'd0, bus.in_ready}, 16'd1);

    // Basic R-type: op1 rd5 rs2 rt3
    accept(16'h1A98);
    chk("r_rf_addr", {10'd0, bus.rf_rs, bus.rf_rt}, {10'd0, 3'd2, 3'd3});
    wait_out("r", lat);
    chk("r_latency", 16'(lat), 16'd2);
    chk("r_op_rd_imm", {bus.out_op, bus.out_rd, bus.out_is_imm}, {4'h1, 3'd5, 1'b0});
    chk("r_ab", {bus.out_a, bus.out_b}, 16'h1122);
    chk("r_imm", {8'd0, bus.out_imm}, 16'h0000);
    issue();
    chk("r_valid_clr", {15'd0, bus.out_valid}, 16'd0);

    // I-type: op8 rd=rs=6 imm 7F
    accept(16'h8C7F);
    wait_out("i", lat);
    chk("i_latency", 16'(lat), 16'd2);
    chk("i_op_rd_imm", {bus.out_op, bus.out_rd, bus.out_is_imm}, {4'h8, 3'd6, 1'b1});
    chk("i_ab", {bus.out_a, bus.out_b}, 16'h4000);
    chk("i_imm", {8'd0, bus.out_imm}, 16'h007F);
    issue();
    wb(3'd6, 8'h41);
    wb(3'd5, 8'h55);

    // RAW: issue write to r5 while accepting a reader of r5 on the same edge
    accept(16'h2A98);
    wait_out("raw_w", lat);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h3940;
    #1;
    chk("b2b_in_ready", {15'd0, bus.in_ready}, 16'd1);
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("raw_rf_rs", {13'd0, bus.rf_rs}, 16'd5);
    step();
    step();
    step();
    chk("raw_stalled", {15'd0, bus.out_valid}, 16'd0);
    wb(3'd5, 8'h77);
    wait_out("raw_r", lat);
    chk("raw_latency", 16'(lat), 16'd2);
    chk("raw_ab", {bus.out_a, bus.out_b}, 16'h7700);
    chk("raw_rd", {13'd0, bus.out_rd}, 16'd4);
    issue();

    // Writeback to unrelated r1 during READ
    accept(16'h1298);
    wb(3'd1, 8'h99);
    wait_out("wbc", lat);
    chk("wbc_latency", 16'(lat), 16'd2);
    chk("wbc_ab", {bus.out_a, bus.out_b}, 16'h1122);
    issue();

    // wb_rd=5 on the same edge as issue of rd=5: busy[5] must survive
    accept(16'h2A98);
    wait_out("col_w", lat);
    bus.out_ready = 1'b1;
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 3'd5;
    wb_data       = 8'h66;
    step();
    bus.out_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    accept(16'h3940);
    step();
    step();
    step();
    chk("col_stalled", {15'd0, bus.out_valid}, 16'd0);
    wb(3'd5, 8'h5A);
    wait_out("col_r", lat);
    chk("col_latency", 16'(lat), 16'd2);
    chk("col_a", {8'd0, bus.out_a}, 16'h005A);
    issue();
    wb(3'd4, 8'h00);
    wb(3'd1, 8'h00);

    // r0 operands with backpressure
    accept(16'h1800);
    wait_out("r0", lat);
    chk("r0_latency", 16'(lat), 16'd2);
    chk("r0_ab", {bus.out_a, bus.out_b}, 16'h0000);
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h1A98;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_stable", {bus.out_valid, bus.in_ready, bus.out_rd, 3'd0, bus.out_op, 4'd0},
          {1'b1, 1'b0, 3'd4, 3'd0, 4'h1, 4'd0});
    end
    issue();
    bus.in_valid = 1'b0;
    wait_out("bp_next", lat);
    chk("bp_next_ab", {bus.out_a, bus.out_b}, 16'h1122);
    issue();

    // OUT and NOP force rd=0 and leave r7 free
    accept(16'h6FC0);
    wait_out("out", lat);
    chk("out_rd_a", {5'd0, bus.out_rd, bus.out_a}, 16'h003C);
    issue();
    accept(16'h0FFF);
    wait_out("nop", lat);
    chk("nop_fields", {1'b0, bus.out_rd, bus.out_op, bus.out_a}, 16'h0000);
    chk("nop_b", {8'd0, bus.out_b}, 16'h0000);
    issue();
    accept(16'h3DC0);
    wait_out("r7", lat);
    chk("r7_latency", 16'(lat), 16'd2);
    chk("r7_a", {8'd0, bus.out_a}, 16'h003C);
    issue();

    // Reset while a stalled reader of busy r5 sits in READ
    accept(16'h3940);
    step();
    reset = 1'b1;
    step();
    chk("mrst_state", {bus.out_valid, bus.in_ready, 8'd0, bus.rf_rs, bus.rf_rt},
        16'h0000);
    reset = 1'b0;
    step();
    step();
    step();
    step();
    chk("mrst_no_issue", {15'd0, bus.out_valid}, 16'd0);
    accept(16'h3940);
    wait_out("mrst_r5", lat);
    chk("mrst_latency", 16'(lat), 16'd2);
    chk("mrst_a", {8'd0, bus.out_a}, 16'h005A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
